icache_sa: RTL and testbench

- Parametrised set-associative, blocking instruction cache with physically-indexed, physically-tagged lookup.
- Sits between the fetch stage and L2. It performs single-word lookups, refills a full line from L2 on a miss, applies selectable replacement, and supports a whole-cache FENCE.I invalidate.
- Next generation of the first I$. Adds a complete FSM, an L2 request/response handshake, a replacement policy, and hit/miss event outputs.

---
 rtl/icache_sa.sv | 231 +++++++++++++++++++++++
 tb/tb_icache_sa.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_sa.sv
// Blocking set-associative instruction cache: single-word lookup, whole-line
// refill from L2 on a miss, round-robin or tree pseudo-LRU replacement, FENCE.I flush.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | ready for a fetch request (not during a flush pulse)
// S_LOOKUP  | tag compare on the indexed set, hit/miss pulse
// S_L2_REQ  | line-aligned refill request held until L2 accepts it
// S_L2_WAIT | waiting for the refill line; installs it unless a flush hit the refill
// S_RESP    | instruction held until fetch accepts it
module icache_sa #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_SIZE   = 64,
    parameter int WAYS        = 2,
    parameter int CACHE_SIZE  = 16384,
    parameter int REPL_PLRU   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     cpu_req_valid_i,
    output logic                     cpu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]    cpu_addr_i,
    output logic                     cpu_resp_valid_o,
    input  logic                     cpu_resp_ready_i,
    output logic [INSTR_WIDTH-1:0]   cpu_resp_instr_o,
    output logic                     l2_req_valid_o,
    input  logic                     l2_req_ready_i,
    output logic [ADDR_WIDTH-1:0]    l2_req_addr_o,
    input  logic                     l2_resp_valid_i,
    output logic                     l2_resp_ready_o,
    input  logic [LINE_SIZE*8-1:0]   l2_resp_data_i,
    output logic                     hit_o,
    output logic                     miss_o
);

    localparam int SETS      = CACHE_SIZE / (WAYS * LINE_SIZE);
    localparam int OFFSET    = $clog2(LINE_SIZE);
    localparam int INDEX     = $clog2(SETS);
    localparam int TAG       = ADDR_WIDTH - OFFSET - INDEX;
    localparam int LINE_BITS = LINE_SIZE * 8;
    localparam int WSEL      = OFFSET - 2;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LOG_W     = $clog2(WAYS);
    localparam int PW        = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_L2_REQ,
        S_L2_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:2]   r_addr;
    logic [LINE_BITS-1:0]    r_data  [SETS][WAYS];
    logic [TAG-1:0]          r_tag   [SETS][WAYS];
    logic [WAYS-1:0]         r_valid [SETS];
    logic [WAY_W-1:0]        r_rr    [SETS];
    logic [PW-1:0]           r_plru  [SETS];
    logic [WAY_W-1:0]        r_victim;
    logic                    r_flush_pending;
    logic [INSTR_WIDTH-1:0]  r_instr;

    logic [TAG-1:0]          w_tag;
    logic [INDEX-1:0]        w_index;
    logic [WSEL-1:0]         w_word;
    logic [WAYS-1:0]         w_hit_vec;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic                    w_inv_found;
    logic [WAY_W-1:0]        w_victim;
    logic                    w_req_fire;
    logic                    w_l2_fire;
    logic                    w_install;
    logic                    w_unused;

    // Tree nodes are heap-numbered from 1; a node bit of 0 points the victim to the lower half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] t);
        int node;
        node = 1;
        for (int l = 0; l < LOG_W; l++) begin
            node = 2 * node + int'(t[node-1]);
        end
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WAY_W-1:0] w);
        logic [PW-1:0] r;
        logic          dir;
        int            node;
        r    = t;
        node = 1;
        for (int l = 0; l < LOG_W; l++) begin
            dir       = w[LOG_W-1-l];
            r[node-1] = ~dir;
            node      = 2 * node + int'(dir);
        end
        return r;
    endfunction

    assign w_tag    = r_addr[ADDR_WIDTH-1 -: TAG];
    assign w_index  = r_addr[OFFSET +: INDEX];
    assign w_word   = r_addr[OFFSET-1:2];
    assign w_unused = ^cpu_addr_i[1:0];

    always_comb begin
        w_hit_vec   = '0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_index][w] && (r_tag[w_index][w] == w_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_index][w]) begin
                w_victim    = WAY_W'(w);
                w_inv_found = 1'b1;
            end
        end
        w_hit = |w_hit_vec;
        if (!w_inv_found) begin
            w_victim = (REPL_PLRU != 0) ? plru_victim(r_plru[w_index]) : r_rr[w_index];
        end
    end

    always_comb begin
        w_next           = r_state;
        cpu_req_ready_o  = 1'b0;
        cpu_resp_valid_o = 1'b0;
        l2_req_valid_o   = 1'b0;
        l2_resp_ready_o  = 1'b0;
        hit_o            = 1'b0;
        miss_o           = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so the port is low the moment reset asserts.
                cpu_req_ready_o = !flush_i && !rst_i;
                if (cpu_req_valid_i && cpu_req_ready_o) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                hit_o  = w_hit;
                miss_o = !w_hit;
                w_next = w_hit ? S_RESP : S_L2_REQ;
            end
            S_L2_REQ: begin
                l2_req_valid_o = 1'b1;
                if (l2_req_ready_i) w_next = S_L2_WAIT;
            end
            S_L2_WAIT: begin
                l2_resp_ready_o = 1'b1;
                if (l2_resp_valid_i) w_next = S_RESP;
            end
            S_RESP: begin
                cpu_resp_valid_o = 1'b1;
                if (cpu_resp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_req_fire       = cpu_req_valid_i && cpu_req_ready_o;
    assign w_l2_fire        = (r_state == S_L2_WAIT) && l2_resp_valid_i;
    assign w_install        = w_l2_fire && !r_flush_pending;
    assign l2_req_addr_o    = {w_tag, w_index, {OFFSET{1'b0}}};
    assign cpu_resp_instr_o = r_instr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_victim        <= '0;
            r_flush_pending <= 1'b0;
            r_instr         <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_req_fire) r_addr <= cpu_addr_i[ADDR_WIDTH-1:2];
            if (r_state == S_LOOKUP) begin
                if (w_hit) r_instr <= r_data[w_index][w_hit_way][{w_word, 5'b0} +: INSTR_WIDTH];
                else       r_victim <= w_victim;
            end
            if (w_l2_fire) r_instr <= l2_resp_data_i[{w_word, 5'b0} +: INSTR_WIDTH];

            if (w_l2_fire) begin
                r_flush_pending <= 1'b0;
            end else if (flush_i && (r_state == S_L2_REQ || r_state == S_L2_WAIT)) begin
                r_flush_pending <= 1'b1;
            end

            // A flush in the fill cycle wins: the line is dropped and replacement state cleared.
            if (flush_i) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[s] <= '0;
                    r_rr[s]    <= '0;
                    r_plru[s]  <= '0;
                end
            end else begin
                if ((r_state == S_LOOKUP) && w_hit && (REPL_PLRU != 0)) begin
                    r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
                end
                if (w_install) begin
                    r_valid[w_index][r_victim] <= 1'b1;
                    if (REPL_PLRU != 0) begin
                        r_plru[w_index] <= plru_touch(r_plru[w_index], r_victim);
                    end else if (&r_valid[w_index]) begin
                        r_rr[w_index] <= (WAYS == 1) ? '0 : r_rr[w_index] + WAY_W'(1);
                    end
                end
            end
        end
    end

    // Data and tags are written even when the fill is dropped; the valid bit alone decides.
    always_ff @(posedge clk_i) begin
        if (w_l2_fire) begin
            r_data[w_index][r_victim] <= l2_resp_data_i;
            r_tag[w_index][r_victim]  <= w_tag;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: one round-robin and one pseudo-LRU instance,
// expected instructions queued at request time and checked on response.
module tb_icache_sa;

    localparam int LB = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst           [2];
    logic          flush         [2];
    logic          req_valid     [2];
    logic [31:0]   req_addr      [2];
    logic          resp_ready    [2];
    logic          l2_req_ready  [2];
    logic          l2_resp_valid [2];
    logic [LB-1:0] l2_data       [2];

    logic          req_ready     [2];
    logic          resp_valid    [2];
    logic [31:0]   resp_instr    [2];
    logic          l2_req_valid  [2];
    logic [31:0]   l2_req_addr   [2];
    logic          l2_resp_ready [2];
    logic          hit           [2];
    logic          miss          [2];

    icache_sa #(.REPL_PLRU(0)) u_rr (
        .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]),
        .cpu_req_valid_i(req_valid[0]), .cpu_req_ready_o(req_ready[0]), .cpu_addr_i(req_addr[0]),
        .cpu_resp_valid_o(resp_valid[0]), .cpu_resp_ready_i(resp_ready[0]), .cpu_resp_instr_o(resp_instr[0]),
        .l2_req_valid_o(l2_req_valid[0]), .l2_req_ready_i(l2_req_ready[0]), .l2_req_addr_o(l2_req_addr[0]),
        .l2_resp_valid_i(l2_resp_valid[0]), .l2_resp_ready_o(l2_resp_ready[0]), .l2_resp_data_i(l2_data[0]),
        .hit_o(hit[0]), .miss_o(miss[0])
    );

    icache_sa #(.REPL_PLRU(1)) u_plru (
        .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]),
        .cpu_req_valid_i(req_valid[1]), .cpu_req_ready_o(req_ready[1]), .cpu_addr_i(req_addr[1]),
        .cpu_resp_valid_o(resp_valid[1]), .cpu_resp_ready_i(resp_ready[1]), .cpu_resp_instr_o(resp_instr[1]),
        .l2_req_valid_o(l2_req_valid[1]), .l2_req_ready_i(l2_req_ready[1]), .l2_req_addr_o(l2_req_addr[1]),
        .l2_resp_valid_i(l2_resp_valid[1]), .l2_resp_ready_o(l2_resp_ready[1]), .l2_resp_data_i(l2_data[1]),
        .hit_o(hit[1]), .miss_o(miss[1])
    );

    int          n_err = 0;
    int          n_chk = 0;
    int          hit_cnt  [2] = '{0, 0};
    int          miss_cnt [2] = '{0, 0};
    logic [31:0] sb [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (hit[i] === 1'b1)  hit_cnt[i]  = hit_cnt[i] + 1;
            if (miss[i] === 1'b1) miss_cnt[i] = miss_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == 32'h0000_1004) return 32'hDEAD_BEEF;
        return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [LB-1:0] gen_line(input logic [31:0] la);
        logic [LB-1:0] l;
        for (int k = 0; k < LB / 32; k++) l[32*k +: 32] = gen_word(la + 32'(4 * k));
        return l;
    endfunction

    function automatic logic [31:0] ctrl_outs(input int id);
        return {26'b0, req_ready[id], resp_valid[id], l2_req_valid[id],
                l2_resp_ready[id], hit[id], miss[id]};
    endfunction

    task automatic do_reset(input int id);
        rst[id] = 1'b1;
        @(negedge clk);
        chk("reset_ctrl_outs", ctrl_outs(id), 32'h0);
        chk("reset_instr", resp_instr[id], 32'h0);
        chk("reset_l2_addr", l2_req_addr[id], 32'h0);
        rst[id] = 1'b0;
        @(negedge clk);
        chk("reset_release_ready", 32'(req_ready[id]), 32'h1);
    endtask

    task automatic wait_accept(input int id, input logic [31:0] addr);
        int n;
        req_valid[id] = 1'b1;
        req_addr[id]  = addr;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_timeout", 32'(n < 50), 32'h1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_addr[id]  = '0;
    endtask

    task automatic fetch(input int id, input logic [31:0] addr, input bit exp_hit,
                         input int l2_delay, input int req_stall, input int resp_stall,
                         input bit flush_mid);
        logic [31:0] laddr, expw;
        int h0, m0;
        laddr = addr & ~32'h3F;
        sb.push_back(gen_word(addr));
        h0 = hit_cnt[id];
        m0 = miss_cnt[id];
        wait_accept(id, addr);
        chk("lookup_hit", 32'(hit[id]), 32'(exp_hit));
        chk("lookup_miss", 32'(miss[id]), 32'(!exp_hit));
        if (!exp_hit) begin
            @(negedge clk);
            for (int i = 0; i <= req_stall; i++) begin
                chk("l2_req_valid_hold", 32'(l2_req_valid[id]), 32'h1);
                chk("l2_req_addr", l2_req_addr[id], laddr);
                if (i < req_stall) @(negedge clk);
            end
            l2_req_ready[id] = 1'b1;
            @(negedge clk);
            l2_req_ready[id] = 1'b0;
            chk("l2_req_single", 32'(l2_req_valid[id]), 32'h0);
            chk("l2_resp_ready", 32'(l2_resp_ready[id]), 32'h1);
            for (int i = 0; i < l2_delay; i++) begin
                flush[id] = flush_mid && (i == 0);
                @(negedge clk);
            end
            flush[id]         = 1'b0;
            l2_resp_valid[id] = 1'b1;
            l2_data[id]       = gen_line(laddr);
            @(negedge clk);
            l2_resp_valid[id] = 1'b0;
            l2_data[id]       = '0;
        end else begin
            @(negedge clk);
            chk("no_l2_req_on_hit", 32'(l2_req_valid[id]), 32'h0);
        end
        chk("resp_latency", 32'(resp_valid[id]), 32'h1);
        chk("hit_pulses", 32'(hit_cnt[id] - h0), exp_hit ? 32'h1 : 32'h0);
        chk("miss_pulses", 32'(miss_cnt[id] - m0), exp_hit ? 32'h0 : 32'h1);
        expw = sb.pop_front();
        for (int i = 0; i <= resp_stall; i++) begin
            chk("resp_valid_hold", 32'(resp_valid[id]), 32'h1);
            chk("resp_instr", resp_instr[id], expw);
            if (i < resp_stall) @(negedge clk);
        end
        resp_ready[id] = 1'b1;
        @(negedge clk);
        resp_ready[id] = 1'b0;
        chk("resp_done", 32'(resp_valid[id]), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; flush[i] = 1'b0; req_valid[i] = 1'b0; req_addr[i] = '0;
            resp_ready[i] = 1'b0; l2_req_ready[i] = 1'b0; l2_resp_valid[i] = 1'b0; l2_data[i] = '0;
        end
        do_reset(0);
        do_reset(1);

        // cold miss, then hit with response backpressure
        fetch(0, 32'h0000_1004, 1'b0, 3, 0, 0, 1'b0);
        fetch(0, 32'h0000_1004, 1'b1, 0, 0, 4, 1'b0);

        // round-robin eviction within set 64
        fetch(0, 32'h0000_3004, 1'b0, 2, 0, 0, 1'b0);
        fetch(0, 32'h0000_5004, 1'b0, 2, 0, 0, 1'b0);
        fetch(0, 32'h0000_3004, 1'b1, 0, 0, 0, 1'b0);
        fetch(0, 32'h0000_1004, 1'b0, 1, 0, 0, 1'b0);
        fetch(0, 32'h0000_5004, 1'b1, 0, 0, 0, 1'b0);
        fetch(0, 32'h0000_3004, 1'b0, 1, 0, 0, 1'b0);
        fetch(0, 32'h0000_1004, 1'b1, 0, 0, 0, 1'b0);

        // L2 request backpressure
        fetch(0, 32'h0000_0A08, 1'b0, 2, 5, 0, 1'b0);

        // flush while the refill is outstanding: word delivered, line not installed
        fetch(0, 32'h0000_2000, 1'b0, 4, 0, 0, 1'b1);
        fetch(0, 32'h0000_2000, 1'b0, 1, 0, 0, 1'b0);
        fetch(0, 32'h0000_2000, 1'b1, 0, 0, 0, 1'b0);

        // flush in IDLE
        flush[0] = 1'b1;
        @(negedge clk);
        chk("ready_low_in_flush", 32'(req_ready[0]), 32'h0);
        flush[0] = 1'b0;
        @(negedge clk);
        chk("ready_after_flush", 32'(req_ready[0]), 32'h1);
        fetch(0, 32'h0000_1004, 1'b0, 1, 0, 0, 1'b0);
        fetch(0, 32'h0000_0A08, 1'b0, 1, 0, 0, 1'b0);
        fetch(0, 32'h0000_2000, 1'b0, 1, 0, 0, 1'b0);

        // async reset while in L2_WAIT
        wait_accept(0, 32'h0000_6004);
        chk("rst_seq_miss", 32'(miss[0]), 32'h1);
        @(negedge clk);
        l2_req_ready[0] = 1'b1;
        @(negedge clk);
        l2_req_ready[0] = 1'b0;
        chk("rst_seq_in_wait", 32'(l2_resp_ready[0]), 32'h1);
        #2 rst[0] = 1'b1;
        #1;
        chk("async_rst_ctrl_outs", ctrl_outs(0), 32'h0);
        chk("async_rst_l2_addr", l2_req_addr[0], 32'h0);
        chk("async_rst_instr", resp_instr[0], 32'h0);
        @(negedge clk);
        rst[0] = 1'b0;
        l2_resp_valid[0] = 1'b1;
        l2_data[0] = gen_line(32'h0000_6000);
        @(negedge clk);
        chk("late_l2_resp_ignored", 32'(l2_resp_ready[0]), 32'h0);
        chk("late_l2_no_resp", 32'(resp_valid[0]), 32'h0);
        @(negedge clk);
        l2_resp_valid[0] = 1'b0;
        l2_data[0] = '0;
        fetch(0, 32'h0000_6004, 1'b0, 2, 0, 0, 1'b0);
        fetch(0, 32'h0000_1004, 1'b0, 1, 0, 0, 1'b0);

        // pseudo-LRU: touching way0 before the third fill makes way1 the victim
        fetch(1, 32'h0000_1004, 1'b0, 3, 0, 0, 1'b0);
        fetch(1, 32'h0000_3004, 1'b0, 1, 0, 0, 1'b0);
        fetch(1, 32'h0000_1004, 1'b1, 0, 0, 0, 1'b0);
        fetch(1, 32'h0000_5004, 1'b0, 1, 0, 0, 1'b0);
        fetch(1, 32'h0000_1004, 1'b1, 0, 0, 0, 1'b0);
        fetch(1, 32'h0000_5004, 1'b1, 0, 0, 0, 1'b0);
        fetch(1, 32'h0000_3004, 1'b0, 1, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
